// File: rtl/nrzi_dec.sv
// NRZI line decoder with SYNC detection, bit unstuffing and per-packet bit count.
// All outputs are registered one clk after the line sample that produced them.
module nrzi_dec (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       bstr_in,
  input  logic       bstr_in_ready,
  output logic       bstr_out,
  output logic       bstr_out_ready,
  output logic       sync_found,
  output logic       stuff_err,
  output logic       pkt_end,
  output logic [6:0] bit_cnt
);

  localparam int unsigned CNT_W       = 7;
  localparam int unsigned ZC_W        = 4;
  localparam int unsigned OC_W        = 3;
  localparam int unsigned SYNC_ZEROS  = 7;
  localparam int unsigned ZERO_LIMIT  = 8;
  localparam int unsigned ONES_LIMIT  = 6;
  localparam int unsigned BIT_CNT_MAX = 127;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_prev_level;
  logic [ZC_W-1:0]   r_zero_cnt;
  logic [OC_W-1:0]   r_ones_cnt;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_bstr_out;
  logic              r_bstr_out_ready;
  logic              r_sync_found;
  logic              r_stuff_err;
  logic              r_pkt_end;
  logic              w_dec;
  logic [ZC_W-1:0]   w_zero_inc;

  // No level change on the line decodes as 1.
  assign w_dec      = (bstr_in == r_prev_level);
  assign w_zero_inc = r_zero_cnt + ZC_W'(1);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state          <= IDLE;
      r_prev_level     <= 1'b1;
      r_zero_cnt       <= '0;
      r_ones_cnt       <= '0;
      r_bit_cnt        <= '0;
      r_bstr_out       <= 1'b0;
      r_bstr_out_ready <= 1'b0;
      r_sync_found     <= 1'b0;
      r_stuff_err      <= 1'b0;
      r_pkt_end        <= 1'b0;
    end else begin
      r_bstr_out       <= 1'b0;
      r_bstr_out_ready <= 1'b0;
      r_sync_found     <= 1'b0;
      r_stuff_err      <= 1'b0;
      r_pkt_end        <= 1'b0;

      if (!bstr_in_ready) begin
        // Line idle: restore the J-state reference and end any open packet.
        r_state      <= IDLE;
        r_prev_level <= 1'b1;
        r_zero_cnt   <= '0;
        r_ones_cnt   <= '0;
        if (r_state == DATA) begin
          r_pkt_end <= 1'b1;
        end
      end else begin
        r_prev_level <= bstr_in;
        case (r_state)
          IDLE: begin
            if (!w_dec) begin
              r_state    <= SYNC;
              r_zero_cnt <= ZC_W'(1);
            end
          end

          SYNC: begin
            if (!w_dec) begin
              r_zero_cnt <= w_zero_inc;
              if (w_zero_inc == ZC_W'(ZERO_LIMIT)) begin
                r_state <= ERR;
              end
            end else if (r_zero_cnt == ZC_W'(SYNC_ZEROS)) begin
              r_state      <= DATA;
              r_sync_found <= 1'b1;
              r_ones_cnt   <= OC_W'(1);
              r_bit_cnt    <= '0;
            end else begin
              r_state <= ERR;
            end
          end

          DATA: begin
            if (r_ones_cnt == OC_W'(ONES_LIMIT)) begin
              // A zero after six ones is a stuffed bit; a seventh one is illegal.
              if (w_dec) begin
                r_stuff_err <= 1'b1;
                r_state     <= ERR;
              end else begin
                r_ones_cnt <= '0;
              end
            end else begin
              r_bstr_out       <= w_dec;
              r_bstr_out_ready <= 1'b1;
              if (r_bit_cnt != CNT_W'(BIT_CNT_MAX)) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              end
              if (w_dec) begin
                r_ones_cnt <= r_ones_cnt + OC_W'(1);
              end else begin
                r_ones_cnt <= '0;
              end
            end
          end

          ERR: begin
            r_state <= ERR;
          end

          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bstr_out       = r_bstr_out;
  assign bstr_out_ready = r_bstr_out_ready;
  assign sync_found     = r_sync_found;
  assign stuff_err      = r_stuff_err;
  assign pkt_end        = r_pkt_end;
  assign bit_cnt        = r_bit_cnt;

endmodule

// File: tb/tb_nrzi_dec.sv
// Directed bench for nrzi_dec: SYNC, payload decode, unstuffing, stuff errors,
// bad SYNC, saturation and mid-packet reset, with hand-derived expectations.
module tb_nrzi_dec;

  logic       clk;
  logic       rst_b;
  logic       bstr_in;
  logic       bstr_in_ready;
  logic       bstr_out;
  logic       bstr_out_ready;
  logic       sync_found;
  logic       stuff_err;
  logic       pkt_end;
  logic [6:0] bit_cnt;

  int n_chk;
  int n_pass;

  nrzi_dec dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .bstr_in        (bstr_in),
    .bstr_in_ready  (bstr_in_ready),
    .bstr_out       (bstr_out),
    .bstr_out_ready (bstr_out_ready),
    .sync_found     (sync_found),
    .stuff_err      (stuff_err),
    .pkt_end        (pkt_end),
    .bit_cnt        (bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one line sample; returns 1 time unit after the edge that registers it.
  task automatic step(input logic lvl, input logic rdy);
    bstr_in       = lvl;
    bstr_in_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Line 0,1,0,1,0,1,0,0 from a J (1) reference: seven decoded 0s then a 1.
  task automatic send_sync();
    logic pat [8];
    pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      step(pat[i], 1'b1);
      n_chk++;
      if (bstr_out_ready !== 1'b0) $display("FAIL sync_no_out[%0d]: got %b want 0", i, bstr_out_ready);
      else n_pass++;
      if (i < 7) begin
        n_chk++;
        if (sync_found !== 1'b0) $display("FAIL sync_early[%0d]: got %b want 0", i, sync_found);
        else n_pass++;
      end
    end
    n_chk++;
    if (sync_found !== 1'b1) $display("FAIL sync_pulse: got %b want 1", sync_found);
    else n_pass++;
    n_chk++;
    if (bit_cnt !== 7'd0) $display("FAIL sync_bitcnt_clr: got %0d want 0", bit_cnt);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_b = 1'b0; bstr_in = 1'b0; bstr_in_ready = 1'b0;
    #2;
    n_chk++;
    if ({bstr_out, bstr_out_ready, sync_found, stuff_err, pkt_end} !== 5'b0)
      $display("FAIL reset_outs: got %b want 00000", {bstr_out, bstr_out_ready, sync_found, stuff_err, pkt_end});
    else n_pass++;
    n_chk++;
    if (bit_cnt !== 7'd0) $display("FAIL reset_bitcnt: got %0d want 0", bit_cnt);
    else n_pass++;
    @(posedge clk); #1;
    rst_b = 1'b1;
    step(1'b1, 1'b0);
  endtask

  task automatic test_sync();
    send_sync();
    step(1'b0, 1'b0);
    n_chk++;
    if (sync_found !== 1'b0) $display("FAIL sync_one_cycle: got %b want 0", sync_found);
    else n_pass++;
    n_chk++;
    if (pkt_end !== 1'b1) $display("FAIL sync_pkt_end_empty: got %b want 1", pkt_end);
    else n_pass++;
  endtask

  task automatic test_payload();
    logic lv  [4];
    logic exp [4];
    lv  = '{1'b0, 1'b1, 1'b0, 1'b0};
    exp = '{1'b1, 1'b0, 1'b0, 1'b1};
    step(1'b1, 1'b0);
    send_sync();
    for (int i = 0; i < 4; i++) begin
      step(lv[i], 1'b1);
      n_chk++;
      if ({bstr_out_ready, bstr_out} !== {1'b1, exp[i]})
        $display("FAIL payload_bit[%0d]: got rdy=%b out=%b want rdy=1 out=%b", i, bstr_out_ready, bstr_out, exp[i]);
      else n_pass++;
    end
    step(1'b1, 1'b0);
    n_chk++;
    if ({pkt_end, bstr_out_ready, bstr_out} !== 3'b100)
      $display("FAIL payload_pkt_end: got pe=%b rdy=%b out=%b want 1,0,0", pkt_end, bstr_out_ready, bstr_out);
    else n_pass++;
    n_chk++;
    if (bit_cnt !== 7'd4) $display("FAIL payload_bitcnt: got %0d want 4", bit_cnt);
    else n_pass++;
    step(1'b1, 1'b0);
    n_chk++;
    if ({pkt_end, bit_cnt} !== {1'b0, 7'd4}) $display("FAIL payload_hold: got pe=%b cnt=%0d want 0,4", pkt_end, bit_cnt);
    else n_pass++;
  endtask

  task automatic test_unstuff();
    send_sync();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1);
      n_chk++;
      if ({bstr_out_ready, bstr_out} !== 2'b11)
        $display("FAIL unstuff_one[%0d]: got rdy=%b out=%b want 1,1", i, bstr_out_ready, bstr_out);
      else n_pass++;
    end
    step(1'b1, 1'b1);
    n_chk++;
    if ({bstr_out_ready, bstr_out, stuff_err} !== 3'b000)
      $display("FAIL unstuff_drop: got rdy=%b out=%b err=%b want 0,0,0", bstr_out_ready, bstr_out, stuff_err);
    else n_pass++;
    n_chk++;
    if (bit_cnt !== 7'd5) $display("FAIL unstuff_bitcnt: got %0d want 5", bit_cnt);
    else n_pass++;
    step(1'b1, 1'b1);
    n_chk++;
    if ({bstr_out_ready, bstr_out} !== 2'b11) $display("FAIL unstuff_after1: got rdy=%b out=%b want 1,1", bstr_out_ready, bstr_out);
    else n_pass++;
    step(1'b0, 1'b1);
    n_chk++;
    if ({bstr_out_ready, bstr_out} !== 2'b10) $display("FAIL unstuff_after0: got rdy=%b out=%b want 1,0", bstr_out_ready, bstr_out);
    else n_pass++;
    step(1'b1, 1'b0);
    n_chk++;
    if ({pkt_end, bit_cnt} !== {1'b1, 7'd7}) $display("FAIL unstuff_end: got pe=%b cnt=%0d want 1,7", pkt_end, bit_cnt);
    else n_pass++;
  endtask

  task automatic test_stuff_err();
    logic lv [3];
    lv = '{1'b1, 1'b1, 1'b0};
    send_sync();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1);
      n_chk++;
      if (bstr_out_ready !== 1'b1) $display("FAIL serr_deliver[%0d]: got %b want 1", i, bstr_out_ready);
      else n_pass++;
    end
    step(1'b0, 1'b1);
    n_chk++;
    if ({stuff_err, bstr_out_ready} !== 2'b10) $display("FAIL serr_pulse: got err=%b rdy=%b want 1,0", stuff_err, bstr_out_ready);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step(lv[i], 1'b1);
      n_chk++;
      if ({stuff_err, bstr_out_ready, sync_found} !== 3'b000)
        $display("FAIL serr_quiet[%0d]: got err=%b rdy=%b sync=%b want 0,0,0", i, stuff_err, bstr_out_ready, sync_found);
      else n_pass++;
    end
    step(1'b1, 1'b0);
    n_chk++;
    if ({pkt_end, bit_cnt} !== {1'b0, 7'd5}) $display("FAIL serr_no_end: got pe=%b cnt=%0d want 0,5", pkt_end, bit_cnt);
    else n_pass++;
    send_sync();
    step(1'b1, 1'b0);
  endtask

  task automatic test_bad_sync();
    logic lv  [5];
    logic pat [8];
    lv  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      step(lv[i], 1'b1);
      n_chk++;
      if ({sync_found, bstr_out_ready, stuff_err} !== 3'b000)
        $display("FAIL bad_sync[%0d]: got sync=%b rdy=%b err=%b want 0,0,0", i, sync_found, bstr_out_ready, stuff_err);
      else n_pass++;
    end
    // A valid-looking pattern while stuck in the error state must be ignored.
    for (int i = 0; i < 8; i++) begin
      step(pat[i], 1'b1);
      n_chk++;
      if ({sync_found, bstr_out_ready} !== 2'b00)
        $display("FAIL bad_sync_err[%0d]: got sync=%b rdy=%b want 0,0", i, sync_found, bstr_out_ready);
      else n_pass++;
    end
    step(1'b1, 1'b0);
    n_chk++;
    if (pkt_end !== 1'b0) $display("FAIL bad_sync_no_end: got %b want 0", pkt_end);
    else n_pass++;
    send_sync();
    step(1'b1, 1'b0);
  endtask

  task automatic test_zero_overflow();
    logic pat [9];
    pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 9; i++) begin
      step(pat[i], 1'b1);
      n_chk++;
      if (sync_found !== 1'b0) $display("FAIL zero_ovf[%0d]: got %b want 0", i, sync_found);
      else n_pass++;
    end
    step(1'b1, 1'b0);
  endtask

  task automatic test_saturate();
    send_sync();
    for (int i = 0; i < 130; i++) begin
      step((i % 2 == 0) ? 1'b1 : 1'b0, 1'b1);
      if (i == 125) begin
        n_chk++;
        if (bit_cnt !== 7'd126) $display("FAIL sat_126: got %0d want 126", bit_cnt);
        else n_pass++;
      end
    end
    n_chk++;
    if ({bstr_out_ready, bit_cnt} !== {1'b1, 7'd127}) $display("FAIL sat_127: got rdy=%b cnt=%0d want 1,127", bstr_out_ready, bit_cnt);
    else n_pass++;
    step(1'b1, 1'b0);
    n_chk++;
    if ({pkt_end, bit_cnt} !== {1'b1, 7'd127}) $display("FAIL sat_end: got pe=%b cnt=%0d want 1,127", pkt_end, bit_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    send_sync();
    for (int i = 0; i < 10; i++) step((i % 2 == 0) ? 1'b1 : 1'b0, 1'b1);
    n_chk++;
    if ({bstr_out_ready, bit_cnt} !== {1'b1, 7'd10}) $display("FAIL rmid_pre: got rdy=%b cnt=%0d want 1,10", bstr_out_ready, bit_cnt);
    else n_pass++;
    #2 rst_b = 1'b0;
    #1;
    n_chk++;
    if ({bstr_out, bstr_out_ready, sync_found, stuff_err, pkt_end, bit_cnt} !== 12'b0)
      $display("FAIL rmid_async: got out=%b rdy=%b sync=%b err=%b pe=%b cnt=%0d want all 0",
               bstr_out, bstr_out_ready, sync_found, stuff_err, pkt_end, bit_cnt);
    else n_pass++;
    bstr_in_ready = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    step(1'b1, 1'b0);
    n_chk++;
    if (pkt_end !== 1'b0) $display("FAIL rmid_no_end: got %b want 0", pkt_end);
    else n_pass++;
    send_sync();
    step(1'b1, 1'b0);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_sync();
    test_payload();
    test_unstuff();
    test_stuff_err();
    test_bad_sync();
    test_zero_overflow();
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
